// File: rtl/div_seq_pkg.sv
// Shared types and constants for the MIX DIV sequencer.
// Build option: DIV_OVF_SHORTCUT_EN (see div_sequencer.sv).
package div_seq_pkg;

    localparam int DIV_W       = 30;
    localparam int DIV_TIMEOUT = 31;
    localparam int WCNT_W      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    // True on the last WAIT cycle the core is allowed before abort.
    function automatic logic tmo_reached(input logic [WCNT_W-1:0] cnt, input int limit);
        return cnt == WCNT_W'(limit - 1);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Applies MIX DIV sign rules and the overflow pass-through of the original rA/rX.
module div_sign_fix
    import div_seq_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         ra_sign,
    input  logic         v_sign,
    input  logic [W-1:0] ra_mag,
    input  logic [W-1:0] rx_mag,
    input  logic [W-1:0] q_mag,
    input  logic [W-1:0] r_mag,
    input  logic         ovf,
    output logic         qa_sign,
    output logic [W-1:0] qa_mag,
    output logic         rx_sign,
    output logic [W-1:0] rx_mag_out
);

    // On overflow rA comes back untouched, sign included.
    assign qa_sign = ovf ? ra_sign : (ra_sign ^ v_sign);
    assign rx_sign = ra_sign;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mag
            assign qa_mag[gi]     = ovf ? ra_mag[gi] : q_mag[gi];
            assign rx_mag_out[gi] = ovf ? rx_mag[gi] : r_mag[gi];
        end
    endgenerate

endmodule

// File: rtl/div_sequencer.sv
// Sequences MIX DIV around an external unsigned divider core.
// Build option: DIV_OVF_SHORTCUT_EN skips the core when overflow is known up front.
module div_sequencer
    import div_seq_pkg::*;
#(
    parameter int W       = DIV_W,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           ra_sign,
    input  logic [W-1:0]   ra_mag,
    input  logic [W-1:0]   rx_mag,
    input  logic           v_sign,
    input  logic [W-1:0]   v_mag,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           qa_sign,
    output logic [W-1:0]   qa_mag,
    output logic           rx_sign_o,
    output logic [W-1:0]   rx_mag_o,
    output logic           ovf,
    output logic           tmo,
    output logic           core_start,
    output logic [W-1:0]   core_a,
    output logic [2*W-1:0] core_c,
    input  logic           core_stop,
    input  logic [W-1:0]   core_b,
    input  logic [W-1:0]   core_rest
);

`ifdef DIV_OVF_SHORTCUT_EN
    localparam bit OVF_SHORTCUT = 1'b1;
`else
    localparam bit OVF_SHORTCUT = 1'b0;
`endif

    state_t              state_reg;
    logic                ra_sign_reg;
    logic                v_sign_reg;
    logic [W-1:0]        ra_mag_reg;
    logic [W-1:0]        rx_mag_reg;
    logic [W-1:0]        v_mag_reg;
    logic                ovf_d_reg;
    logic [WCNT_W-1:0]   wcnt_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic                core_start_reg;
    logic                qa_sign_reg;
    logic [W-1:0]        qa_mag_reg;
    logic                rx_sign_reg;
    logic [W-1:0]        rx_mag_reg_o;
    logic                ovf_reg;
    logic                tmo_reg;

    logic                ovf_now;
    logic                tmo_hit;
    logic                fix_ovf;
    logic                fix_qa_sign;
    logic [W-1:0]        fix_qa_mag;
    logic                fix_rx_sign;
    logic [W-1:0]        fix_rx_mag;

    // Quotient would not fit one word (or divide by zero).
    assign ovf_now = (v_mag_reg == '0) | (ra_mag_reg >= v_mag_reg);
    assign tmo_hit = tmo_reached(wcnt_reg, TIMEOUT);

    always_comb begin
        fix_ovf = ovf_d_reg;
        if (state_reg == S_CHECK) begin
            fix_ovf = ovf_now;
        end else if (state_reg == S_WAIT && !core_stop && tmo_hit) begin
            fix_ovf = 1'b1;
        end
    end

    div_sign_fix #(.W(W)) u_sign_fix (
        .ra_sign    (ra_sign_reg),
        .v_sign     (v_sign_reg),
        .ra_mag     (ra_mag_reg),
        .rx_mag     (rx_mag_reg),
        .q_mag      (core_b),
        .r_mag      (core_rest),
        .ovf        (fix_ovf),
        .qa_sign    (fix_qa_sign),
        .qa_mag     (fix_qa_mag),
        .rx_sign    (fix_rx_sign),
        .rx_mag_out (fix_rx_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            ra_sign_reg    <= 1'b0;
            v_sign_reg     <= 1'b0;
            ra_mag_reg     <= '0;
            rx_mag_reg     <= '0;
            v_mag_reg      <= '0;
            ovf_d_reg      <= 1'b0;
            wcnt_reg       <= '0;
            req_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            core_start_reg <= 1'b0;
            qa_sign_reg    <= 1'b0;
            qa_mag_reg     <= '0;
            rx_sign_reg    <= 1'b0;
            rx_mag_reg_o   <= '0;
            ovf_reg        <= 1'b0;
            tmo_reg        <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        ra_sign_reg   <= ra_sign;
                        v_sign_reg    <= v_sign;
                        ra_mag_reg    <= ra_mag;
                        rx_mag_reg    <= rx_mag;
                        v_mag_reg     <= v_mag;
                        req_ready_reg <= 1'b0;
                        state_reg     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    ovf_d_reg <= ovf_now;
                    if (OVF_SHORTCUT && ovf_now) begin
                        qa_sign_reg   <= fix_qa_sign;
                        qa_mag_reg    <= fix_qa_mag;
                        rx_sign_reg   <= fix_rx_sign;
                        rx_mag_reg_o  <= fix_rx_mag;
                        ovf_reg       <= 1'b1;
                        tmo_reg       <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        core_start_reg <= 1'b1;
                        state_reg      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wcnt_reg  <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_stop || tmo_hit) begin
                        qa_sign_reg   <= fix_qa_sign;
                        qa_mag_reg    <= fix_qa_mag;
                        rx_sign_reg   <= fix_rx_sign;
                        rx_mag_reg_o  <= fix_rx_mag;
                        ovf_reg       <= fix_ovf;
                        tmo_reg       <= !core_stop;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign qa_sign    = qa_sign_reg;
    assign qa_mag     = qa_mag_reg;
    assign rx_sign_o  = rx_sign_reg;
    assign rx_mag_o   = rx_mag_reg_o;
    assign ovf        = ovf_reg;
    assign tmo        = tmo_reg;
    assign core_start = core_start_reg;
    assign core_a     = v_mag_reg;
    assign core_c     = {ra_mag_reg, rx_mag_reg};

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer with a behavioural 11-cycle divider core.
module tb_div_sequencer;

    localparam int W = 30;

`ifdef DIV_OVF_SHORTCUT_EN
    localparam int OVF_LAT    = 2;
    localparam int OVF_STARTS = 0;
`else
    localparam int OVF_LAT    = 14;
    localparam int OVF_STARTS = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           ra_sign = 1'b0;
    logic [W-1:0]   ra_mag = '0;
    logic [W-1:0]   rx_mag = '0;
    logic           v_sign = 1'b0;
    logic [W-1:0]   v_mag = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           qa_sign;
    logic [W-1:0]   qa_mag;
    logic           rx_sign_o;
    logic [W-1:0]   rx_mag_o;
    logic           ovf;
    logic           tmo;
    logic           core_start;
    logic [W-1:0]   core_a;
    logic [2*W-1:0] core_c;
    logic           core_stop = 1'b0;
    logic [W-1:0]   core_b = '0;
    logic [W-1:0]   core_rest = '0;

    logic           stop_en = 1'b1;
    logic [3:0]     core_cnt = '0;
    int             start_cnt = 0;
    int             vec_cnt = 0;
    int             err_cnt = 0;

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ra_sign    (ra_sign),
        .ra_mag     (ra_mag),
        .rx_mag     (rx_mag),
        .v_sign     (v_sign),
        .v_mag      (v_mag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .qa_sign    (qa_sign),
        .qa_mag     (qa_mag),
        .rx_sign_o  (rx_sign_o),
        .rx_mag_o   (rx_mag_o),
        .ovf        (ovf),
        .tmo        (tmo),
        .core_start (core_start),
        .core_a     (core_a),
        .core_c     (core_c),
        .core_stop  (core_stop),
        .core_b     (core_b),
        .core_rest  (core_rest)
    );

    // Divider core stand-in: stop pulses 11 cycles after start is sampled, no reset.
    always @(posedge clk) begin
        if (core_start) begin
            core_cnt <= 4'd10;
            if (core_a == '0) begin
                core_b    <= '0;
                core_rest <= '0;
            end else begin
                core_b    <= W'(core_c / {{W{1'b0}}, core_a});
                core_rest <= W'(core_c % {{W{1'b0}}, core_a});
            end
        end else if (core_cnt != 4'd0) begin
            core_cnt <= core_cnt - 4'd1;
        end
        core_stop <= stop_en && (core_cnt == 4'd1);
        if (core_start) start_cnt <= start_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic run_div(input string tag,
                           input logic s_a, input logic [W-1:0] a, input logic [W-1:0] x,
                           input logic s_v, input logic [W-1:0] v,
                           input logic e_qs, input logic [W-1:0] e_q,
                           input logic e_rs, input logic [W-1:0] e_r,
                           input logic e_ovf, input logic e_tmo,
                           input int e_lat, input int e_starts, input int hold);
        int n;
        int s0;
        s0        = start_cnt;
        ra_sign   = s_a;
        ra_mag    = a;
        rx_mag    = x;
        v_sign    = s_v;
        v_mag     = v;
        req_valid = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        $display("txn %s: lat=%0d qa=%s%0d rx=%s%0d ovf=%0d tmo=%0d", tag, n,
                 qa_sign ? "-" : "+", qa_mag, rx_sign_o ? "-" : "+", rx_mag_o, ovf, tmo);
        check_val({tag, ".lat"},   64'(n),       64'(e_lat));
        check_val({tag, ".qs"},    64'(qa_sign), 64'(e_qs));
        check_val({tag, ".qa"},    64'(qa_mag),  64'(e_q));
        check_val({tag, ".rs"},    64'(rx_sign_o), 64'(e_rs));
        check_val({tag, ".rx"},    64'(rx_mag_o), 64'(e_r));
        check_val({tag, ".ovf"},   64'(ovf),     64'(e_ovf));
        check_val({tag, ".tmo"},   64'(tmo),     64'(e_tmo));
        check_val({tag, ".rrdy"},  64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (hold > 0) begin
            check_val({tag, ".hold_vld"}, 64'(rsp_valid), 64'd1);
            check_val({tag, ".hold_qa"},  64'(qa_mag),    64'(e_q));
            check_val({tag, ".hold_rx"},  64'(rx_mag_o),  64'(e_r));
            check_val({tag, ".hold_rdy"}, 64'(req_ready), 64'd0);
        end
        check_val({tag, ".starts"}, 64'(start_cnt - s0), 64'(e_starts));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_val({tag, ".vld_drop"}, 64'(rsp_valid), 64'd0);
        check_val({tag, ".idle"},     64'(req_ready), 64'd1);
    endtask

    initial begin
        int hi_cnt;
        int s0;
        repeat (3) @(negedge clk);
        check_val("rst.rrdy",  64'(req_ready),  64'd1);
        check_val("rst.vld",   64'(rsp_valid),  64'd0);
        check_val("rst.start", 64'(core_start), 64'd0);
        check_val("rst.ovf",   64'(ovf),        64'd0);
        check_val("rst.tmo",   64'(tmo),        64'd0);
        check_val("rst.qa",    64'(qa_mag),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //        tag      sA    rA    rX    sV    V     qs    qa          rs    rx    ovf   tmo   lat  starts hold
        run_div("pos",    1'b0, 30'd0, 30'd100, 1'b0, 30'd7, 1'b0, 30'd14, 1'b0, 30'd2, 1'b0, 1'b0, 14, 1, 0);
        run_div("negz",   1'b1, 30'd0, 30'd100, 1'b0, 30'd7, 1'b1, 30'd14, 1'b1, 30'd2, 1'b0, 1'b0, 14, 1, 0);
        run_div("negv",   1'b0, 30'd0, 30'd100, 1'b1, 30'd7, 1'b1, 30'd14, 1'b0, 30'd2, 1'b0, 1'b0, 14, 1, 0);
        run_div("negboth",1'b1, 30'd0, 30'd100, 1'b1, 30'd7, 1'b0, 30'd14, 1'b1, 30'd2, 1'b0, 1'b0, 14, 1, 0);
        run_div("vzero",  1'b1, 30'd3, 30'd55,  1'b1, 30'd0, 1'b1, 30'd3,  1'b1, 30'd55, 1'b1, 1'b0, OVF_LAT, OVF_STARTS, 0);
        run_div("aeqv",   1'b0, 30'd5, 30'd9,   1'b0, 30'd5, 1'b0, 30'd5,  1'b0, 30'd9, 1'b1, 1'b0, OVF_LAT, OVF_STARTS, 0);
        run_div("altv",   1'b0, 30'd4, 30'd0,   1'b0, 30'd5, 1'b0, 30'd858993459, 1'b0, 30'd1, 1'b0, 1'b0, 14, 1, 0);
        run_div("hold",   1'b0, 30'd0, 30'd1000,1'b0, 30'd9, 1'b0, 30'd111, 1'b0, 30'd1, 1'b0, 1'b0, 14, 1, 10);

        stop_en = 1'b0;
        run_div("tmo",    1'b0, 30'd0, 30'd100, 1'b0, 30'd7, 1'b0, 30'd0,  1'b0, 30'd100, 1'b1, 1'b1, 34, 1, 0);
        stop_en = 1'b1;

        // Reset pulse in WAIT; the core's late stop must not produce a response.
        s0        = start_cnt;
        ra_sign   = 1'b0;
        ra_mag    = 30'd0;
        rx_mag    = 30'd50;
        v_sign    = 1'b0;
        v_mag     = 30'd3;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rstw.rrdy", 64'(req_ready), 64'd1);
        check_val("rstw.vld",  64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (rsp_valid) hi_cnt++;
        end
        $display("txn rst_wait: starts=%0d stray_rsp_cycles=%0d", start_cnt - s0, hi_cnt);
        check_val("rstw.stray", 64'(hi_cnt), 64'd0);
        check_val("rstw.rrdy2", 64'(req_ready), 64'd1);
        check_val("rstw.starts", 64'(start_cnt - s0), 64'd1);

        run_div("post_rst", 1'b0, 30'd1, 30'd0, 1'b0, 30'd2, 1'b0, 30'd536870912, 1'b0, 30'd0, 1'b0, 1'b0, 14, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
